// File: rtl/ternary_pkg.sv
// Shared types, trit constants, op codes and FSM states for the ternary word unit.
// TERNARY_ILLEGAL_CHECK_EN selects how the illegal code 11 is decoded.
package ternary_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_0 = 2'b00;
    localparam trit_t TRIT_1 = 2'b01;
    localparam trit_t TRIT_2 = 2'b10;
    localparam trit_t TRIT_X = 2'b11;

    typedef enum logic [2:0] {
        OP_MAX  = 3'b000,
        OP_MIN  = 3'b001,
        OP_CONS = 3'b010,
        OP_ANY  = 3'b011,
        OP_ADD  = 3'b100
    } ternary_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Illegal trits are cleaned once at accept so the ALU only ever sees 0/1/2.
    function automatic trit_t norm_trit(input trit_t t);
`ifdef TERNARY_ILLEGAL_CHECK_EN
        return (t == TRIT_X) ? TRIT_0 : t;
`else
        return (t == TRIT_X) ? TRIT_2 : t;
`endif
    endfunction

    function automatic logic op_reserved(input logic [2:0] op);
        return op > OP_ADD;
    endfunction

endpackage

// File: rtl/ternary_trit_alu.sv
// Combinational single-trit ALU: one result trit plus carry in/out (carry used by ADD only).
module ternary_trit_alu
    import ternary_pkg::*;
(
    input  logic [2:0] op,
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] c_in,
    output logic [1:0] y,
    output logic [1:0] c_out
);

    logic [2:0] sum;

    always_comb begin
        y     = TRIT_0;
        c_out = TRIT_0;
        sum   = '0;
        case (op)
            OP_MAX:  y = (a > b) ? a : b;
            OP_MIN:  y = (a < b) ? a : b;
            OP_CONS: y = (a == b) ? a : TRIT_1;
            OP_ANY: begin
                if (a == b)           y = a;
                else if (a == TRIT_1) y = b;
                else if (b == TRIT_1) y = a;
                else                  y = TRIT_1;
            end
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b} + {1'b0, c_in};
                if (sum >= 3'd3) begin
                    y     = trit_t'(sum - 3'd3);
                    c_out = TRIT_1;
                end else begin
                    y = trit_t'(sum);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ternary_word_unit.sv
// Trit-serial word ALU: TPC trits per RUN cycle, results shifted in LSB-first.
// Define TERNARY_ILLEGAL_CHECK_EN to flag 11 trits in out_err and treat them as 0.
module ternary_word_unit
    import ternary_pkg::*;
#(
    parameter int W   = 8,
    parameter int TPC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [2*W-1:0]   in_a,
    input  logic [2*W-1:0]   in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_y,
    output logic [1:0]       out_carry,
    output logic             out_err
);

    localparam int N  = W / TPC;
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [2*W-1:0]   a_q, a_d, b_q, b_d, y_q, y_d;
    logic [GW-1:0]    grp_q, grp_d;
    trit_t            carry_q, carry_d;
    logic             err_q, err_d;

    logic             ready_int;
    logic             load;
    logic [2*TPC-1:0] grp_y;
    logic [2*TPC+1:0] chain;
    logic [2*W-1:0]   grp_y_ext;

    function automatic logic [2*W-1:0] norm_word(input logic [2*W-1:0] w);
        logic [2*W-1:0] r;
        for (int i = 0; i < W; i++) r[2*i +: 2] = norm_trit(w[2*i +: 2]);
        return r;
    endfunction

`ifdef TERNARY_ILLEGAL_CHECK_EN
    function automatic logic has_x(input logic [2*W-1:0] w);
        logic r;
        r = 1'b0;
        for (int i = 0; i < W; i++) r = r | (w[2*i +: 2] == TRIT_X);
        return r;
    endfunction
`endif

    // Carry enters at the low trit of the group and ripples upward.
    assign chain[1:0] = carry_q;
    for (genvar j = 0; j < TPC; j++) begin : g_alu
        ternary_trit_alu u_alu (
            .op    (op_q),
            .a     (a_q[2*j +: 2]),
            .b     (b_q[2*j +: 2]),
            .c_in  (chain[2*j +: 2]),
            .y     (grp_y[2*j +: 2]),
            .c_out (chain[2*(j+1) +: 2])
        );
    end

    assign ready_int = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        y_d       = y_q;
        grp_d     = grp_q;
        carry_d   = carry_q;
        err_d     = err_q;
        load      = 1'b0;
        grp_y_ext = '0;
        grp_y_ext[2*TPC-1:0] = grp_y;
        case (state_q)
            ST_IDLE: load = in_valid;
            ST_RUN: begin
                a_d     = a_q >> (2 * TPC);
                b_d     = b_q >> (2 * TPC);
                y_d     = (y_q >> (2 * TPC)) | (grp_y_ext << (2 * (W - TPC)));
                carry_d = chain[2*TPC +: 2];
                if (grp_q == GW'(N - 1)) state_d = ST_DONE;
                else                     grp_d   = grp_q + 1'b1;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    load    = in_valid;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            state_d = ST_RUN;
            op_d    = in_op;
            a_d     = norm_word(in_a);
            b_d     = norm_word(in_b);
            y_d     = '0;
            grp_d   = '0;
            carry_d = TRIT_0;
`ifdef TERNARY_ILLEGAL_CHECK_EN
            err_d   = op_reserved(in_op) | has_x(in_a) | has_x(in_b);
`else
            err_d   = op_reserved(in_op);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            grp_q   <= '0;
            carry_q <= TRIT_0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            grp_q   <= grp_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = !rst && ready_int;
    assign out_valid = (state_q == ST_DONE);
    assign out_y     = y_q;
    assign out_carry = carry_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_ternary_word_unit.sv
// Directed bench for ternary_word_unit (W=8 with TPC=1, plus a TPC=4 instance for ADD).
module tb_ternary_word_unit;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [2:0]  in_op;
    logic [15:0] in_a, in_b, out_y;
    logic [1:0]  out_carry;

    logic        v4_in_valid, v4_in_ready, v4_out_valid, v4_out_ready, v4_out_err;
    logic [2:0]  v4_in_op;
    logic [15:0] v4_in_a, v4_in_b, v4_out_y;
    logic [1:0]  v4_out_carry;

    int checks   = 0;
    int failures = 0;

    ternary_word_unit #(.W(8), .TPC(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_y(out_y), .out_carry(out_carry), .out_err(out_err)
    );

    ternary_word_unit #(.W(8), .TPC(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4_in_valid), .in_ready(v4_in_ready),
        .in_op(v4_in_op), .in_a(v4_in_a), .in_b(v4_in_b), .out_valid(v4_out_valid),
        .out_ready(v4_out_ready), .out_y(v4_out_y), .out_carry(v4_out_carry),
        .out_err(v4_out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal digits, most significant trit first; digit 3 encodes the illegal 11.
    function automatic logic [15:0] tw(input int d);
        logic [15:0] r;
        int p;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            r[2*i +: 2] = 2'((d / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Called #1 after a rising edge with the unit idle.
    task automatic run_txn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] y, output logic [1:0] c, output logic e,
                           output int lat);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        y = out_y; c = out_carry; e = out_err;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 0; in_op = 0; in_a = 0; in_b = 0; out_ready = 0;
        v4_in_valid = 0; v4_in_op = 0; v4_in_a = 0; v4_in_b = 0; v4_out_ready = 0;
        #2;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++;
        if ({out_valid, out_y, out_carry, out_err} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b y=%h c=%b e=%b exp all 0", out_valid, out_y, out_carry, out_err);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_max_min;
        logic [15:0] y; logic [1:0] c; logic e; int lat;
        run_txn(3'b000, tw(01202102), tw(20110121), y, c, e, lat);
        checks++;
        if (y !== tw(21212122)) begin failures++; $display("FAIL max_y got=%h exp=%h", y, tw(21212122)); end
        checks++;
        if (lat !== 8) begin failures++; $display("FAIL max_latency got=%0d exp=8", lat); end
        checks++;
        if ({c, e} !== 3'b000) begin failures++; $display("FAIL max_carry_err got=%b%b exp=000", c, e); end
        run_txn(3'b001, tw(01202102), tw(20110121), y, c, e, lat);
        checks++;
        if (y !== tw(100101)) begin failures++; $display("FAIL min_y got=%h exp=%h", y, tw(100101)); end
    endtask

    task automatic test_add;
        logic [15:0] y; logic [1:0] c; logic e; int lat;
        run_txn(3'b100, tw(22222222), tw(1), y, c, e, lat);
        checks++;
        if (y !== 16'h0) begin failures++; $display("FAIL add_wrap_y got=%h exp=0000", y); end
        checks++;
        if (c !== 2'b01) begin failures++; $display("FAIL add_wrap_carry got=%b exp=01", c); end
        run_txn(3'b100, tw(121), tw(212), y, c, e, lat);
        checks++;
        if (y !== tw(1110)) begin failures++; $display("FAIL add_mid_y got=%h exp=%h", y, tw(1110)); end
        checks++;
        if ({c, e} !== 3'b000) begin failures++; $display("FAIL add_mid_carry_err got=%b%b exp=000", c, e); end
    endtask

    task automatic test_add_tpc4;
        int lat;
        v4_in_op = 3'b100; v4_in_a = tw(22222222); v4_in_b = tw(1); v4_in_valid = 1'b1;
        @(posedge clk); #1;
        v4_in_valid = 1'b0;
        lat = 0;
        while (!v4_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL tpc4_latency got=%0d exp=2", lat); end
        checks++;
        if ({v4_out_y, v4_out_carry} !== 18'h00001) begin
            failures++;
            $display("FAIL tpc4_add got y=%h c=%b exp y=0000 c=01", v4_out_y, v4_out_carry);
        end
        v4_out_ready = 1'b1;
        @(posedge clk); #1;
        v4_out_ready = 1'b0;
    endtask

    task automatic test_cons_any;
        logic [15:0] y; logic [1:0] c; logic e; int lat;
        run_txn(3'b010, tw(1122), tw(01201202), y, c, e, lat);
        checks++;
        if (y !== tw(01101112)) begin failures++; $display("FAIL cons_y got=%h exp=%h", y, tw(01101112)); end
        run_txn(3'b011, tw(1122), tw(01201202), y, c, e, lat);
        checks++;
        if (y !== tw(00101212)) begin failures++; $display("FAIL any_y got=%h exp=%h", y, tw(00101212)); end
    endtask

    task automatic test_back_to_back;
        int lat;
        in_op = 3'b000; in_a = tw(01202102); in_b = tw(20110121); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (!out_valid || out_y !== tw(21212122) || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_%0d got v=%b y=%h rdy=%b exp v=1 y=%h rdy=0",
                         i, out_valid, out_y, in_ready, tw(21212122));
            end
            @(posedge clk); #1;
        end
        in_op = 3'b100; in_a = tw(121); in_b = tw(212); in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop got=%b exp=0", out_valid); end
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== 8 || out_y !== tw(1110)) begin
            failures++;
            $display("FAIL b2b_second got lat=%0d y=%h exp lat=8 y=%h", lat, out_y, tw(1110));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        logic [15:0] y; logic [1:0] c; logic e; int lat;
        logic seen;
        seen = 1'b0;
        in_op = 3'b100; in_a = tw(22222222); in_b = tw(1); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, out_y, out_carry, out_err} !== 21'h0) begin
            failures++;
            $display("FAIL midrun_reset got rdy=%b v=%b y=%h c=%b e=%b exp all 0",
                     in_ready, out_valid, out_y, out_carry, out_err);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL midrun_no_output got=%b exp=0", seen); end
        run_txn(3'b100, tw(121), tw(212), y, c, e, lat);
        checks++;
        if (y !== tw(1110) || lat !== 8) begin
            failures++;
            $display("FAIL after_reset got y=%h lat=%0d exp y=%h lat=8", y, lat, tw(1110));
        end
    endtask

    task automatic test_reserved;
        logic [15:0] y; logic [1:0] c; logic e; int lat;
        run_txn(3'b110, tw(22222222), tw(11111111), y, c, e, lat);
        checks++;
        if ({y, c, e} !== 19'h1) begin
            failures++;
            $display("FAIL reserved_op got y=%h c=%b e=%b exp y=0000 c=00 e=1", y, c, e);
        end
        run_txn(3'b000, tw(1), tw(2), y, c, e, lat);
        checks++;
        if (e !== 1'b0 || y !== tw(2)) begin
            failures++;
            $display("FAIL err_clears got y=%h e=%b exp y=%h e=0", y, e, tw(2));
        end
    endtask

    task automatic test_illegal;
        logic [15:0] y; logic [1:0] c; logic e; int lat;
        run_txn(3'b000, tw(3), tw(1), y, c, e, lat);
`ifdef TERNARY_ILLEGAL_CHECK_EN
        checks++;
        if (y !== tw(1) || e !== 1'b1) begin
            failures++;
            $display("FAIL illegal_trit got y=%h e=%b exp y=%h e=1", y, e, tw(1));
        end
`else
        checks++;
        if (y !== tw(2) || e !== 1'b0) begin
            failures++;
            $display("FAIL illegal_trit got y=%h e=%b exp y=%h e=0", y, e, tw(2));
        end
`endif
    endtask

    initial begin
        test_reset;
        test_max_min;
        test_add;
        test_add_tpc4;
        test_cons_any;
        test_back_to_back;
        test_reset_mid_run;
        test_reserved;
        test_illegal;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
